// File: rtl/sevenseg_scan_n.sv
// Multiplexed common-anode seven-segment driver with frame-consistent input snapshots,
// per-digit decimal points, blinking, leading-zero blanking and PWM brightness.
module sevenseg_scan_n #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_W    = 17,
    parameter int DUTY_W       = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    msclk,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic [DUTY_W-1:0]       bright,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] LAST_POS   = PW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

    logic [REFRESH_W-1:0]    cnt;
    logic [PW-1:0]           pos;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   mask_sh;
    logic                    blank_lz_sh;
    logic                    frame_end_d;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nibble;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    lz_run;
    logic                    lit;
    logic [7:0]              next_seg;
    logic [NUM_DIGITS-1:0]   next_an;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign slot_end   = &cnt;
    assign frame_end  = slot_end && (pos == LAST_POS);
    assign cur_nibble = digits_sh[{pos, 2'b00} +: 4];

    // A digit is leading-zero blanked when it and every digit to its left are zero.
    always_comb begin
        lz     = '0;
        lz_run = blank_lz_sh;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run = lz_run && (digits_sh[4*i +: 4] == 4'h0);
            lz[i]  = lz_run;
        end
    end

    always_comb begin
        next_seg = 8'hFF;
        next_an  = '1;
        lit = (cnt[REFRESH_W-1 -: DUTY_W] <= bright) && !slot_end
              && !(blink_phase && mask_sh[pos]) && (!lz[pos] || dp_sh[pos]);
        if (lit) begin
            next_an  = ~(NUM_DIGITS'(1) << pos);
            next_seg = lz[pos] ? 8'h7F : {~dp_sh[pos], decode(cur_nibble)};
        end
    end

    // frame_tick is delayed twice so it lines up with the first registered output of digit 0.
    always_ff @(posedge msclk) begin
        if (RST) begin
            cnt         <= '0;
            pos         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            digits_sh   <= '0;
            dp_sh       <= '0;
            mask_sh     <= '0;
            blank_lz_sh <= 1'b0;
            frame_end_d <= 1'b0;
            frame_tick  <= 1'b0;
            seg         <= 8'hFF;
            an          <= '1;
        end else begin
            cnt <= cnt + 1'b1;
            if (slot_end)
                pos <= (pos == LAST_POS) ? '0 : pos + 1'b1;
            if (frame_end) begin
                digits_sh   <= digits;
                dp_sh       <= dp;
                mask_sh     <= blink_mask;
                blank_lz_sh <= blank_lz;
                if (mask_sh == '0) begin
                    blink_cnt   <= '0;
                    blink_phase <= 1'b0;
                end else if (blink_cnt == LAST_BLINK) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            frame_end_d <= frame_end;
            frame_tick  <= frame_end_d;
            seg         <= next_seg;
            an          <= next_an;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Self-checking bench for sevenseg_scan_n: a cycle-index based display model checked
// every cycle, plus directed literal checks that pin the model.
module tb_sevenseg_scan_n;

    localparam int ND    = 4;
    localparam int RW    = 4;
    localparam int DW    = 2;
    localparam int BF    = 2;
    localparam int SLOT  = 1 << RW;
    localparam int FRAME = SLOT * ND;

    logic        msclk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  bright = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: k is the index of the scan cycle since reset, shown_k the one now on the pins.
    int          k = 0;
    int          shown_k = -1;
    bit          model_valid = 1'b0;
    logic [15:0] sh_digits = '0;
    logic [3:0]  sh_dp = '0;
    logic [3:0]  sh_mask = '0;
    logic        sh_blz = 1'b0;
    int          run = 0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_tick = 1'b0;

    always #5 msclk = ~msclk;

    sevenseg_scan_n #(
        .NUM_DIGITS(ND), .REFRESH_W(RW), .DUTY_W(DW), .BLINK_FRAMES(BF)
    ) dut (
        .msclk(msclk), .RST(RST), .digits(digits), .dp(dp), .blink_mask(blink_mask),
        .blank_lz(blank_lz), .bright(bright), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    task automatic checkOutput(input string name, input logic [3:0] e_an,
                               input logic [7:0] e_seg, input logic e_tick);
        n_checks++;
        if (an !== e_an || seg !== e_seg || frame_tick !== e_tick) begin
            n_fail++;
            $display("[TB] FAIL %s at shown=%0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                     name, shown_k, an, seg, frame_tick, e_an, e_seg, e_tick);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                                 input logic [3:0] mask, input logic blz, input logic [1:0] br);
        digits     = d;
        dp         = dpv;
        blink_mask = mask;
        blank_lz   = blz;
        bright     = br;
    endtask

    task automatic waitShown(input int target);
        int guard = 0;
        do begin
            @(negedge msclk);
            guard++;
        end while (shown_k != target && guard < 3000);
        if (shown_k != target) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL wait_shown: reached %0d, expected %0d", shown_k, target);
        end
    endtask

    // Model: outputs follow from the cycle index, the last frame-end snapshot and the
    // number of consecutive frames the blink mask has been active.
    always @(posedge msclk) begin : model
        int          cnt_v;
        int          pos_v;
        logic [15:0] upper;
        bit          lz_v;
        bit          blk_v;
        bit          lit_v;
        model_valid = 1'b1;
        if (RST) begin
            k = 0; shown_k = -1; run = 0;
            sh_digits = '0; sh_dp = '0; sh_mask = '0; sh_blz = 1'b0;
            exp_seg = 8'hFF; exp_an = 4'hF; exp_tick = 1'b0;
        end else begin
            cnt_v = k % SLOT;
            pos_v = (k / SLOT) % ND;
            upper = sh_digits >> (4 * pos_v);
            lz_v  = (pos_v >= 1) && sh_blz && (upper == 16'h0);
            blk_v = (((run / BF) % 2) == 1) && sh_mask[pos_v];
            lit_v = ((cnt_v / (1 << (RW - DW))) <= int'(bright)) && (cnt_v != SLOT - 1)
                    && !blk_v && (!lz_v || sh_dp[pos_v]);
            exp_an   = lit_v ? 4'(~(1 << pos_v)) : 4'hF;
            exp_seg  = !lit_v ? 8'hFF : lz_v ? 8'h7F
                       : ((dec_tab[upper[3:0]] & 8'h7F) | (sh_dp[pos_v] ? 8'h00 : 8'h80));
            exp_tick = (k % FRAME == 0) && (k >= FRAME);
            shown_k  = k;
            if (k % FRAME == FRAME - 1) begin
                run       = (sh_mask != 4'h0) ? run + 1 : 0;
                sh_digits = digits;
                sh_dp     = dp;
                sh_mask   = blink_mask;
                sh_blz    = blank_lz;
            end
            k++;
        end
    end

    always @(negedge msclk) begin
        if (model_valid)
            checkOutput("model", exp_an, exp_seg, exp_tick);
    end

    initial begin
        applyStimulus(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
        RST = 1'b1;
        repeat (3) @(negedge msclk);
        checkOutput("reset", 4'hF, 8'hFF, 1'b0);
        RST = 1'b0;

        waitShown(0);   checkOutput("blank_shadow_d0", 4'b1110, 8'hC0, 1'b0);
        waitShown(16);  checkOutput("blank_shadow_d1", 4'b1101, 8'hC0, 1'b0);
        waitShown(64);  checkOutput("hex_d0_tick", 4'b1110, 8'h8E, 1'b1);
        waitShown(65);  checkOutput("hex_d0_notick", 4'b1110, 8'h8E, 1'b0);
        waitShown(78);  checkOutput("hex_d0_last", 4'b1110, 8'h8E, 1'b0);
        waitShown(79);  checkOutput("ghost_gap", 4'hF, 8'hFF, 1'b0);
        waitShown(80);  checkOutput("hex_d1", 4'b1101, 8'h88, 1'b0);
        waitShown(96);  checkOutput("hex_d2", 4'b1011, 8'hA4, 1'b0);
        waitShown(112); checkOutput("hex_d3", 4'b0111, 8'hF9, 1'b0);

        applyStimulus(16'h0050, 4'b0100, 4'h0, 1'b1, 2'd3);
        waitShown(128); checkOutput("lz_d0", 4'b1110, 8'hC0, 1'b1);
        waitShown(144); checkOutput("lz_d1", 4'b1101, 8'h92, 1'b0);
        waitShown(160); checkOutput("lz_d2_dp", 4'b1011, 8'h7F, 1'b0);
        waitShown(176); checkOutput("lz_d3_dark", 4'hF, 8'hFF, 1'b0);
        applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
        waitShown(192); checkOutput("lz_zero_d0", 4'b1110, 8'hC0, 1'b1);
        waitShown(208); checkOutput("lz_zero_d1", 4'hF, 8'hFF, 1'b0);
        waitShown(224); checkOutput("lz_zero_d2", 4'hF, 8'hFF, 1'b0);

        applyStimulus(16'h8888, 4'h0, 4'h0, 1'b0, 2'd0);
        waitShown(256); checkOutput("dim_first", 4'b1110, 8'h80, 1'b1);
        waitShown(259); checkOutput("dim_last", 4'b1110, 8'h80, 1'b0);
        waitShown(260); checkOutput("dim_off", 4'hF, 8'hFF, 1'b0);
        waitShown(271);
        applyStimulus(16'h8888, 4'h0, 4'h0, 1'b0, 2'd2);
        waitShown(272); checkOutput("mid_first", 4'b1101, 8'h80, 1'b0);
        waitShown(283); checkOutput("mid_last", 4'b1101, 8'h80, 1'b0);
        waitShown(284); checkOutput("mid_off", 4'hF, 8'hFF, 1'b0);

        applyStimulus(16'h8888, 4'h0, 4'b0001, 1'b0, 2'd3);
        waitShown(320); checkOutput("blink_vis_a", 4'b1110, 8'h80, 1'b1);
        waitShown(384); checkOutput("blink_vis_b", 4'b1110, 8'h80, 1'b1);
        waitShown(448); checkOutput("blink_dark_a", 4'hF, 8'hFF, 1'b1);
        waitShown(464); checkOutput("blink_other", 4'b1101, 8'h80, 1'b0);
        waitShown(512); checkOutput("blink_dark_b", 4'hF, 8'hFF, 1'b1);
        applyStimulus(16'h8888, 4'h0, 4'h0, 1'b0, 2'd3);
        waitShown(576); checkOutput("blink_cleared", 4'b1110, 8'h80, 1'b1);

        applyStimulus(16'h1111, 4'h0, 4'h0, 1'b0, 2'd3);
        waitShown(640); checkOutput("snap_old_d0", 4'b1110, 8'hF9, 1'b1);
        waitShown(676);
        applyStimulus(16'h2222, 4'h0, 4'h0, 1'b0, 2'd3);
        waitShown(677); checkOutput("snap_mid_d2", 4'b1011, 8'hF9, 1'b0);
        waitShown(696); checkOutput("snap_old_d3", 4'b0111, 8'hF9, 1'b0);
        waitShown(703); checkOutput("snap_gap", 4'hF, 8'hFF, 1'b0);
        waitShown(704); checkOutput("snap_new_d0", 4'b1110, 8'hA4, 1'b1);

        waitShown(790);
        RST = 1'b1;
        @(negedge msclk);
        checkOutput("reset_mid", 4'hF, 8'hFF, 1'b0);
        RST = 1'b0;
        waitShown(0);  checkOutput("restart_d0", 4'b1110, 8'hC0, 1'b0);
        waitShown(64); checkOutput("restart_load", 4'b1110, 8'hA4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
